msp_spi_slave: RTL and testbench

- SPI target (ICE40 side) for the MSP430 command link, i.e. the receiver for the MSP-driven ice_msp_spi_clk / ice_msp_spi_data lines.
- Oversamples MSP SPI clock/data in the single system clock domain and shifts in fixed-length commands MSB-first.
- Presents each complete command as a one-cycle strobe, then shifts a response word back on the shared data line after a turnaround gap.
- Sits between the top-level MSP pins and the command decoder of the ICE app.

---
 rtl/msp_spi_slave.sv | 144 ++++++++++++++
 tb/tb_msp_spi_slave.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/msp_spi_slave.sv
// SPI target for the MSP430 command link: oversamples the MSP clock/data, collects a
// fixed-length command, then returns a response word after a turnaround gap.
module msp_spi_slave #(
    parameter int CMD_W        = 64,
    parameter int RESP_W       = 64,
    parameter int TURN_CLKS    = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              spi_clk,
    input  logic              spi_data_in,
    output logic              spi_data_out,
    output logic              spi_data_oe,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_data,
    input  logic [RESP_W-1:0] resp_data,
    output logic              busy
);

    localparam int MAX_CR = (CMD_W > RESP_W) ? CMD_W : RESP_W;
    localparam int MAX_W  = (MAX_CR > TURN_CLKS) ? MAX_CR : TURN_CLKS;
    localparam int CNT_W  = $clog2(MAX_W) + 1;
    localparam int TO_W   = $clog2(IDLE_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_TURN,
        ST_RESP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [CMD_W-1:0]    rx_shift;
    logic [RESP_W-1:0]   tx_shift;
    logic [2:0]          clk_sync;
    logic [1:0]          data_sync;
    logic                rise;
    logic                fall;
    logic                sdata;
    logic                timeout_hit;

    // NOTE: the synchronizer chain is deliberately left out of reset so that a reset
    // taken while spi_clk is high cannot fabricate a rising edge afterwards.
    always_ff @(posedge clk) begin
        clk_sync  <= {clk_sync[1:0], spi_clk};
        data_sync <= {data_sync[0], spi_data_in};
    end

    assign rise        = clk_sync[1] & ~clk_sync[2];
    assign fall        = ~clk_sync[1] & clk_sync[2];
    assign sdata       = data_sync[1];
    assign timeout_hit = busy & ~clk_sync[1] & (to_cnt == TO_W'(IDLE_TIMEOUT - 1));

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the values from before this clock edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state        <= ST_CMD;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            spi_data_out <= 1'b1;
            spi_data_oe  <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_data     <= '0;
            busy         <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;

            if (clk_sync[1] || !busy || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            // A stalled MSP abandons whatever frame was in progress.
            if (timeout_hit) begin
                state        <= ST_CMD;
                bit_cnt      <= '0;
                spi_data_oe  <= 1'b0;
                spi_data_out <= 1'b1;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (rise) begin
                            rx_shift <= {rx_shift[CMD_W-2:0], sdata};
                            busy     <= 1'b1;
                            if (bit_cnt == CNT_W'(CMD_W - 1)) begin
                                cmd_data  <= {rx_shift[CMD_W-2:0], sdata};
                                cmd_valid <= 1'b1;
                                state     <= ST_TURN;
                                bit_cnt   <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_TURN: begin
                        spi_data_oe <= 1'b0;
                        if (rise) begin
                            if (bit_cnt == CNT_W'(TURN_CLKS - 1)) begin
                                tx_shift <= resp_data;
                                state    <= ST_RESP;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_RESP: begin
                        // bit_cnt counts MSP sample edges; the fall after the last one releases the line.
                        if (rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (fall) begin
                            if (bit_cnt == CNT_W'(RESP_W)) begin
                                spi_data_oe  <= 1'b0;
                                spi_data_out <= 1'b1;
                                state        <= ST_CMD;
                                bit_cnt      <= '0;
                                busy         <= 1'b0;
                            end else begin
                                spi_data_oe  <= 1'b1;
                                spi_data_out <= tx_shift[RESP_W-1];
                                tx_shift     <= {tx_shift[RESP_W-2:0], 1'b0};
                            end
                        end
                    end

                    default: begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msp_spi_slave.sv
// Directed bench for msp_spi_slave: an MSP master model running SPI at clk/8,
// with hand-computed commands and responses.
module tb_msp_spi_slave;

    logic        clk = 1'b0;
    logic        rst_;
    logic        spi_clk;
    logic        spi_data_in;
    logic        spi_data_out;
    logic        spi_data_oe;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic [63:0] resp_data;
    logic        busy;

    int checks     = 0;
    int failures   = 0;
    int valid_cnt  = 0;

    msp_spi_slave #(
        .CMD_W(64), .RESP_W(64), .TURN_CLKS(8), .IDLE_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst_(rst_), .spi_clk(spi_clk), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmd_valid === 1'b1) valid_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI clock as the MSP drives it: data changes while low, samples at rise.
    task automatic spi_cycle(input logic mosi, output logic miso, output logic oe);
        spi_clk     = 1'b0;
        spi_data_in = mosi;
        wait_clk(4);
        miso    = spi_data_out;
        oe      = spi_data_oe;
        spi_clk = 1'b1;
        wait_clk(4);
    endtask

    task automatic send_bits(input logic [63:0] word, input int n);
        logic miso, oe;
        for (int i = n - 1; i >= 0; i--) spi_cycle(word[i], miso, oe);
    endtask

    task automatic turnaround(input string tag);
        logic miso, oe;
        for (int i = 0; i < 8; i++) begin
            spi_cycle(1'b1, miso, oe);
            check({tag, "_turn_oe"}, oe, 1'b0);
        end
    endtask

    task automatic recv_bits(input int n, output logic [63:0] got, output logic oe_all);
        logic miso, oe;
        got    = '0;
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            spi_cycle(1'b0, miso, oe);
            got    = {got[62:0], miso};
            oe_all = oe_all & oe;
        end
    endtask

    task automatic full_frame(input string tag, input logic [63:0] cmd, input logic [63:0] resp);
        int          v0;
        logic [63:0] got;
        logic        oe_all;
        v0        = valid_cnt;
        resp_data = resp;
        send_bits(cmd, 64);
        check({tag, "_cmd_data"}, cmd_data, cmd);
        check({tag, "_busy_cmd"}, busy, 1'b1);
        turnaround(tag);
        check({tag, "_valid_pulses"}, 64'(valid_cnt - v0), 64'd1);
        recv_bits(64, got, oe_all);
        check({tag, "_resp"}, got, resp);
        check({tag, "_resp_oe"}, oe_all, 1'b1);
        check({tag, "_busy_resp"}, busy, 1'b1);
        spi_clk = 1'b0;
        wait_clk(6);
        check({tag, "_end_oe"}, spi_data_oe, 1'b0);
        check({tag, "_end_out"}, spi_data_out, 1'b1);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_cmd_hold"}, cmd_data, cmd);
    endtask

    initial begin
        int          v0;
        logic [63:0] got;
        logic        oe_all;

        rst_        = 1'b0;
        spi_clk     = 1'b0;
        spi_data_in = 1'b0;
        resp_data   = '0;
        wait_clk(3);
        rst_ = 1'b1;

        // Idle pins after reset: {oe,out,valid,busy} must stay 0100.
        for (int i = 0; i < 100; i++) begin
            wait_clk(1);
            check("idle", {spi_data_oe, spi_data_out, cmd_valid, busy}, 4'b0100);
        end
        check("idle_cmd_data", cmd_data, 64'h0);

        full_frame("f_deadbeef", 64'hDEAD_BEEF_0123_4567, 64'hA5A5_0000_FFFF_1234);

        // Partial command followed by a long idle low: discarded without a strobe.
        v0 = valid_cnt;
        send_bits(64'hABCDE, 20);
        spi_clk = 1'b0;
        wait_clk(1000);
        check("to_busy_before", busy, 1'b1);
        wait_clk(40);
        check("to_busy_after", busy, 1'b0);
        check("to_oe", spi_data_oe, 1'b0);
        check("to_no_valid", 64'(valid_cnt - v0), 64'd0);
        full_frame("f_one", 64'h1, 64'h8000_0000_0000_0001);

        // Reset pulse while the response is being driven.
        resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        send_bits(64'h3, 64);
        turnaround("f_rst");
        recv_bits(30, got, oe_all);
        check("rst_partial_resp", got, 64'h3FFF_FFFF);
        spi_clk = 1'b0;
        wait_clk(4);
        check("rst_oe_before", spi_data_oe, 1'b1);
        rst_ = 1'b0;
        wait_clk(1);
        rst_ = 1'b1;
        check("rst_oe_after", spi_data_oe, 1'b0);
        check("rst_out_after", spi_data_out, 1'b1);
        check("rst_busy_after", busy, 1'b0);
        check("rst_cmd_data", cmd_data, 64'h0);
        full_frame("f_five", 64'h5, 64'h0123_4567_89AB_CDEF);

        full_frame("f_11", 64'h11, 64'hFEDC_BA98_7654_3210);
        full_frame("f_22", 64'h22, 64'h5A5A_C3C3_0F0F_9669);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
